// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges ALU and memory-load writebacks into a single register-file write port.
// Optional build macro WB_STATS_EN adds the ConflictCnt contention counter output.
module regfile_wb_arbiter (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        AluValid,
    input  logic [3:0]  AluReg,
    input  logic [15:0] AluData,
    output logic        AluReady,
    input  logic        MemValid,
    input  logic [3:0]  MemReg,
    input  logic [15:0] MemData,
    output logic        MemReady,
    output logic        RegWre,
    output logic [3:0]  WriteReg,
    output logic [15:0] WriteData,
`ifdef WB_STATS_EN
    output logic [15:0] ConflictCnt,
`endif
    output logic [15:0] PendMask
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_ALU  = 2'b01;
    localparam logic [1:0] ST_MEM  = 2'b10;

    // Hard-wired zero register code; writes to it are swallowed.
    localparam logic [3:0] REG0 = 4'h0;

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        onehot16 = 16'h0001 << idx;
    endfunction

    logic        alu_full_r;
    logic [3:0]  alu_reg_r;
    logic [15:0] alu_data_r;
    logic        mem_full_r;
    logic [3:0]  mem_reg_r;
    logic [15:0] mem_data_r;
    logic        mem_older_r;
    logic        last_mem_r;
    logic [1:0]  state_r;
    logic [3:0]  wreg_r;
    logic [15:0] wdata_r;

    logic [1:0]  grant_s;
    logic        alu_ready_s;
    logic        mem_ready_s;
    logic        alu_load_s;
    logic        mem_load_s;
    logic [15:0] pend_s;

    // Grant decision for this cycle, taken from the buffer contents before the edge.
    always_comb begin
        grant_s = ST_IDLE;
        case ({alu_full_r, mem_full_r})
            2'b10: grant_s = ST_ALU;
            2'b01: grant_s = ST_MEM;
            2'b11: begin
                if (alu_reg_r == mem_reg_r) begin
                    grant_s = mem_older_r ? ST_MEM : ST_ALU;
                end else begin
                    grant_s = last_mem_r ? ST_ALU : ST_MEM;
                end
            end
            default: grant_s = ST_IDLE;
        endcase
    end

    // A buffer can take a new entry when empty or when it drains on this same edge.
    always_comb begin
        alu_ready_s = Rst & (~alu_full_r | (grant_s == ST_ALU));
        mem_ready_s = Rst & (~mem_full_r | (grant_s == ST_MEM));
        alu_load_s  = AluValid & alu_ready_s & (AluReg != REG0);
        mem_load_s  = MemValid & mem_ready_s & (MemReg != REG0);
        pend_s      = (alu_full_r ? onehot16(alu_reg_r) : 16'h0000)
                    | (mem_full_r ? onehot16(mem_reg_r) : 16'h0000);
    end

    assign AluReady = alu_ready_s;
    assign MemReady = mem_ready_s;
    assign PendMask = pend_s;

    // ALU buffer: refill wins over drain so a granted entry is replaced seamlessly.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            alu_full_r <= 1'b0;
            alu_reg_r  <= 4'h0;
            alu_data_r <= 16'h0000;
        end else if (alu_load_s) begin
            alu_full_r <= 1'b1;
            alu_reg_r  <= AluReg;
            alu_data_r <= AluData;
        end else if (grant_s == ST_ALU) begin
            alu_full_r <= 1'b0;
        end else begin
            alu_full_r <= alu_full_r;
        end
    end

    // Memory buffer, same refill-over-drain behaviour as the ALU side.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            mem_full_r <= 1'b0;
            mem_reg_r  <= 4'h0;
            mem_data_r <= 16'h0000;
        end else if (mem_load_s) begin
            mem_full_r <= 1'b1;
            mem_reg_r  <= MemReg;
            mem_data_r <= MemData;
        end else if (grant_s == ST_MEM) begin
            mem_full_r <= 1'b0;
        end else begin
            mem_full_r <= mem_full_r;
        end
    end

    // Age bit: the most recently loaded entry is the younger; a same-edge pair counts MEM as older.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            mem_older_r <= 1'b0;
        end else if (alu_load_s) begin
            mem_older_r <= 1'b1;
        end else if (mem_load_s) begin
            mem_older_r <= 1'b0;
        end else begin
            mem_older_r <= mem_older_r;
        end
    end

    // Round-robin pointer remembers which source was granted last.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            last_mem_r <= 1'b0;
        end else if (grant_s != ST_IDLE) begin
            last_mem_r <= (grant_s == ST_MEM);
        end else begin
            last_mem_r <= last_mem_r;
        end
    end

    // Grant state and write port; index and data hold their last values while idle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r <= ST_IDLE;
            wreg_r  <= 4'h0;
            wdata_r <= 16'h0000;
        end else begin
            state_r <= grant_s;
            case (grant_s)
                ST_ALU: begin
                    wreg_r  <= alu_reg_r;
                    wdata_r <= alu_data_r;
                end
                ST_MEM: begin
                    wreg_r  <= mem_reg_r;
                    wdata_r <= mem_data_r;
                end
                default: begin
                    wreg_r  <= wreg_r;
                    wdata_r <= wdata_r;
                end
            endcase
        end
    end

    assign RegWre    = (state_r == ST_ALU) | (state_r == ST_MEM);
    assign WriteReg  = wreg_r;
    assign WriteData = wdata_r;

`ifdef WB_STATS_EN
    logic [15:0] conflict_cnt_r;

    // Counts every edge on which both buffers compete; wraps naturally at 16 bits.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            conflict_cnt_r <= 16'h0000;
        end else if (alu_full_r && mem_full_r) begin
            conflict_cnt_r <= conflict_cnt_r + 16'h0001;
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign ConflictCnt = conflict_cnt_r;
`endif

endmodule
